// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a framed image into instruction memory and
// holds the core in reset until the frame checksum matches.
module imem_loader #(
    parameter int unsigned SIZE_ADDR = 10,
    parameter int unsigned SIZE_DATA = 32
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_rx_valid,
    input  logic [7:0]           iw_rx_data,
    output logic                 ow_rx_ready,
    output logic                 ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr,
    output logic [SIZE_DATA-1:0] ow_mem_wdata,
    output logic                 ow_core_rst,
    output logic                 ow_done,
    output logic                 ow_err
);

    localparam int unsigned BPW = SIZE_DATA / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [7:0] HEADER = 8'hA5;

    if ((SIZE_DATA % 8) != 0 || SIZE_DATA < 8) begin : g_bad_size
        $error("imem_loader: SIZE_DATA must be a nonzero multiple of 8");
    end

    typedef enum logic [2:0] {
        StHdr,
        StCntHi,
        StCntLo,
        StData,
        StCsum,
        StRun,
        StErr
    } state_t;

    state_t               state;
    logic [7:0]           count_hi;
    logic [15:0]          words_left;
    logic [BCW-1:0]       byte_idx;
    logic [SIZE_DATA-1:0] word;
    logic [SIZE_DATA-1:0] word_next;
    logic [7:0]           sum;
    logic [SIZE_ADDR-1:0] word_idx;
    logic                 accept;

    assign accept    = iw_rx_valid & ow_rx_ready;
    // Bytes arrive MSB first, so each new byte shifts in at the bottom.
    assign word_next = SIZE_DATA'({word, iw_rx_data});

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state        <= StHdr;
            count_hi     <= '0;
            words_left   <= '0;
            byte_idx     <= '0;
            word         <= '0;
            sum          <= '0;
            word_idx     <= '0;
            ow_rx_ready  <= 1'b0;
            ow_mem_we    <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_wdata <= '0;
            ow_core_rst  <= 1'b1;
            ow_done      <= 1'b0;
            ow_err       <= 1'b0;
        end else begin
            ow_mem_we   <= 1'b0;
            ow_rx_ready <= (state != StRun) && (state != StErr);
            if (accept) begin
                unique case (state)
                    StHdr: begin
                        if (iw_rx_data == HEADER) begin
                            state <= StCntHi;
                        end
                    end
                    StCntHi: begin
                        count_hi <= iw_rx_data;
                        state    <= StCntLo;
                    end
                    StCntLo: begin
                        words_left <= {count_hi, iw_rx_data};
                        byte_idx   <= '0;
                        word_idx   <= '0;
                        sum        <= '0;
                        state      <= ({count_hi, iw_rx_data} == 16'd0) ? StCsum : StData;
                    end
                    StData: begin
                        word <= word_next;
                        sum  <= sum + iw_rx_data;
                        if (byte_idx == BCW'(BPW - 1)) begin
                            byte_idx     <= '0;
                            ow_mem_we    <= 1'b1;
                            ow_mem_addr  <= word_idx;
                            ow_mem_wdata <= word_next;
                            word_idx     <= word_idx + SIZE_ADDR'(1);
                            words_left   <= words_left - 16'd1;
                            if (words_left == 16'd1) begin
                                state <= StCsum;
                            end
                        end else begin
                            byte_idx <= byte_idx + BCW'(1);
                        end
                    end
                    StCsum: begin
                        // RUN and ERR are terminal, so drop ready on the same edge.
                        ow_rx_ready <= 1'b0;
                        if (iw_rx_data == sum) begin
                            state       <= StRun;
                            ow_done     <= 1'b1;
                            ow_core_rst <= 1'b0;
                        end else begin
                            state  <= StErr;
                            ow_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a frame-level parser model predicts the
// write sequence and the final verdict, and a negedge monitor checks every cycle.
module tb_imem_loader;

    localparam int unsigned SA = 8;
    localparam int unsigned SD = 24;

    typedef logic [7:0] byte_t;

    logic          iw_clk = 1'b0;
    logic          iw_rst;
    logic          iw_rx_valid;
    logic [7:0]    iw_rx_data;
    logic          ow_rx_ready;
    logic          ow_mem_we;
    logic [SA-1:0] ow_mem_addr;
    logic [SD-1:0] ow_mem_wdata;
    logic          ow_core_rst;
    logic          ow_done;
    logic          ow_err;

    imem_loader #(
        .SIZE_ADDR(SA),
        .SIZE_DATA(SD)
    ) dut (
        .iw_clk      (iw_clk),
        .iw_rst      (iw_rst),
        .iw_rx_valid (iw_rx_valid),
        .iw_rx_data  (iw_rx_data),
        .ow_rx_ready (ow_rx_ready),
        .ow_mem_we   (ow_mem_we),
        .ow_mem_addr (ow_mem_addr),
        .ow_mem_wdata(ow_mem_wdata),
        .ow_core_rst (ow_core_rst),
        .ow_done     (ow_done),
        .ow_err      (ow_err)
    );

    always #5 iw_clk = ~iw_clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected writes, in order
    logic [SA-1:0] qa[$];
    logic [SD-1:0] qd[$];

    // Frame-level reference: find the header, read N, slice N words, sum payload.
    // outcome: 0 = frame incomplete, 1 = done, 2 = checksum error.
    task automatic model_frame(input byte_t s[$], output int outcome, output int nacc);
        int    p;
        int    n;
        byte_t csum;
        p       = 0;
        csum    = 8'h00;
        outcome = 0;
        nacc    = s.size();
        while (p < s.size() && s[p] != 8'hA5) p++;
        if (p + 2 >= s.size()) return;
        n = {s[p+1], s[p+2]};
        p = p + 3;
        for (int w = 0; w < n; w++) begin
            if (p + 3 > s.size()) return;
            qa.push_back(SA'(w % (1 << SA)));
            qd.push_back({s[p], s[p+1], s[p+2]});
            csum = csum + s[p] + s[p+1] + s[p+2];
            p = p + 3;
        end
        if (p >= s.size()) return;
        outcome = (s[p] == csum) ? 1 : 2;
        nacc    = p + 1;
    endtask

    // Per-cycle monitor
    logic          settled;
    logic          prev_we;
    logic [SA-1:0] last_addr;
    logic [SD-1:0] last_wdata;
    int            wr_seen  = 0;
    int            acc_cnt  = 0;

    always @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) settled <= 1'b0;
        else        settled <= 1'b1;
    end

    always @(posedge iw_clk) begin
        if (!iw_rst && iw_rx_valid && ow_rx_ready) acc_cnt++;
    end

    always @(negedge iw_clk) begin
        if (iw_rst) begin
            prev_we    = 1'b0;
            last_addr  = '0;
            last_wdata = '0;
        end else begin
            check("we pulse width", 32'(prev_we & ow_mem_we), 32'd0);
            if (ow_mem_we) begin
                wr_seen++;
                check("write expected", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    check("write addr", 32'(ow_mem_addr), 32'(qa[0]));
                    check("write data", 32'(ow_mem_wdata), 32'(qd[0]));
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
                last_addr  = ow_mem_addr;
                last_wdata = ow_mem_wdata;
            end else begin
                check("addr hold", 32'(ow_mem_addr), 32'(last_addr));
                check("wdata hold", 32'(ow_mem_wdata), 32'(last_wdata));
            end
            check("core_rst vs done", 32'(ow_core_rst), 32'(!ow_done));
            check("done/err exclusive", 32'(ow_done & ow_err), 32'd0);
            if (settled) check("ready", 32'(ow_rx_ready), 32'(!(ow_done || ow_err)));
            prev_we = ow_mem_we;
        end
    end

    task automatic do_reset();
        @(posedge iw_clk);
        #1 iw_rst = 1'b1;
        #1;
        check("rst core_rst", 32'(ow_core_rst), 32'd1);
        check("rst ready", 32'(ow_rx_ready), 32'd0);
        check("rst we", 32'(ow_mem_we), 32'd0);
        check("rst addr", 32'(ow_mem_addr), 32'd0);
        check("rst wdata", 32'(ow_mem_wdata), 32'd0);
        check("rst done", 32'(ow_done), 32'd0);
        check("rst err", 32'(ow_err), 32'd0);
        qa.delete();
        qd.delete();
        repeat (2) @(posedge iw_clk);
        #1 iw_rst = 1'b0;
        check("ready before first edge", 32'(ow_rx_ready), 32'd0);
        @(posedge iw_clk);
        #1 check("ready after first edge", 32'(ow_rx_ready), 32'd1);
    endtask

    // Drive one byte at a time, randomly idling valid; each byte held until accepted.
    task automatic drive(input byte_t s[$], input int pct);
        for (int i = 0; i < s.size(); i++) begin
            bit hs;
            int guard;
            hs    = 1'b0;
            guard = 0;
            while (!hs) begin
                if ($urandom_range(99) < pct) begin
                    iw_rx_valid = 1'b1;
                    iw_rx_data  = s[i];
                end else begin
                    iw_rx_valid = 1'b0;
                    iw_rx_data  = 8'($urandom);
                end
                hs = iw_rx_valid && ow_rx_ready;
                @(posedge iw_clk);
                #1;
                guard++;
                if (!hs && guard > 1000) begin
                    check("byte accept timeout", 32'(i), 32'(s.size()));
                    iw_rx_valid = 1'b0;
                    return;
                end
            end
        end
        iw_rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input byte_t s[$], input int pct, input bit rst_first);
        int outcome;
        int nacc;
        int acc0;
        if (rst_first) do_reset();
        model_frame(s, outcome, nacc);
        acc0 = acc_cnt;
        drive(s, pct);
        repeat (3) @(posedge iw_clk);
        #1;
        check({name, " done"}, 32'(ow_done), 32'(outcome == 1));
        check({name, " err"}, 32'(ow_err), 32'(outcome == 2));
        check({name, " writes left"}, 32'(qa.size()), 32'd0);
        check({name, " bytes accepted"}, 32'(acc_cnt - acc0), 32'(nacc));
    endtask

    byte_t s_good[$];
    byte_t s_bad[$];
    byte_t s_zero[$];
    byte_t s_part[$];
    byte_t s_rand[$];

    initial begin
        int o;
        int na;
        int w0;
        iw_rst      = 1'b1;
        iw_rx_valid = 1'b0;
        iw_rx_data  = 8'h00;
        #12;
        check("initial core_rst", 32'(ow_core_rst), 32'd1);
        check("initial ready", 32'(ow_rx_ready), 32'd0);

        s_good = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
        s_bad  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h16};
        s_zero = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        s_part = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};

        // Pin the model against hand-derived values
        model_frame(s_good, o, na);
        check("model w0 data", 32'(qd[0]), 32'h010203);
        check("model w1 addr", 32'(qa[1]), 32'd1);
        check("model w1 data", 32'(qd[1]), 32'h040506);
        check("model good outcome", 32'(o), 32'd1);
        qa.delete();
        qd.delete();
        model_frame(s_bad, o, na);
        check("model bad outcome", 32'(o), 32'd2);
        qa.delete();
        qd.delete();
        model_frame(s_zero, o, na);
        check("model zero writes", 32'(qa.size()), 32'd0);
        check("model zero nacc", 32'(na), 32'd6);

        w0 = wr_seen;
        run_frame("good", s_good, 100, 1'b1);
        check("good write count", 32'(wr_seen - w0), 32'd2);
        check("good core_rst", 32'(ow_core_rst), 32'd0);

        w0 = wr_seen;
        run_frame("bad csum", s_bad, 100, 1'b1);
        check("bad write count", 32'(wr_seen - w0), 32'd2);
        check("bad core_rst", 32'(ow_core_rst), 32'd1);

        w0 = wr_seen;
        run_frame("zero words", s_zero, 100, 1'b1);
        check("zero write count", 32'(wr_seen - w0), 32'd0);

        run_frame("good stalled", s_good, 40, 1'b1);

        // Partial frame then reset; the word-0 write must land before the reset.
        w0 = wr_seen;
        run_frame("partial", s_part, 100, 1'b1);
        check("partial write count", 32'(wr_seen - w0), 32'd1);
        run_frame("resend", s_good, 100, 1'b1);

        for (int t = 0; t < 12; t++) begin
            int    n;
            byte_t cs;
            s_rand.delete();
            repeat ($urandom_range(3)) begin
                byte_t g;
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                s_rand.push_back(g);
            end
            n  = $urandom_range(5);
            cs = 8'h00;
            s_rand.push_back(8'hA5);
            s_rand.push_back(8'h00);
            s_rand.push_back(8'(n));
            for (int b = 0; b < 3 * n; b++) begin
                byte_t d;
                d  = 8'($urandom);
                cs = cs + d;
                s_rand.push_back(d);
            end
            if ($urandom_range(3) == 0) cs = cs ^ 8'(1 + $urandom_range(254));
            s_rand.push_back(cs);
            run_frame("random", s_rand, 30 + $urandom_range(70), 1'b1);
        end

        // Long frame to exercise address wrap
        s_rand.delete();
        begin
            byte_t cs;
            cs = 8'h00;
            s_rand.push_back(8'hA5);
            s_rand.push_back(8'h01);
            s_rand.push_back(8'h04);
            for (int b = 0; b < 3 * 260; b++) begin
                byte_t d;
                d  = 8'($urandom);
                cs = cs + d;
                s_rand.push_back(d);
            end
            s_rand.push_back(cs);
        end
        w0 = wr_seen;
        run_frame("wrap", s_rand, 100, 1'b1);
        check("wrap write count", 32'(wr_seen - w0), 32'd260);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
